// File: rtl/inst_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// inst_fetch: PC owner issuing credit-limited imem reads, buffering words for the decoder.  Rev 1.0
// ----------------------------------------------------------------------------

package corePckg;
  localparam int cXLEN = 32;
endpackage

module inst_fetch
  import corePckg::*;
#(
  parameter logic [cXLEN-1:0] pResetPc  = 32'h0000_0000,
  parameter int               pBufDepth = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  output logic             oMemReq,
  output logic [cXLEN-1:0] oMemAddr,
  input  logic             iMemGnt,
  input  logic             iMemRspDv,
  input  logic [cXLEN-1:0] iMemRspData,
  input  logic             iStall,
  input  logic             iRedirect,
  input  logic [cXLEN-1:0] iRedirectPc,
  output logic [cXLEN-1:0] oInst,
  output logic [cXLEN-1:0] oCurPc,
  output logic             oInstDv
);

  localparam int               cPtrW  = $clog2(pBufDepth);
  localparam int               cCntW  = cPtrW + 1;
  localparam logic [cXLEN-1:0] cNop   = 32'h0000_0013;
  localparam logic [cCntW:0]   cDepth = (cCntW + 1)'(pBufDepth);

  logic [cXLEN-1:0] fetchPc_q, fetchPc_d;
  logic             memReq_q, memReq_d;
  logic [cCntW-1:0] outst_q, outst_d;
  logic [cCntW-1:0] discard_q, discard_d;
  logic [cCntW-1:0] bufCnt_q, bufCnt_d;
  logic [cPtrW-1:0] bufWr_q, bufWr_d, bufRd_q, bufRd_d;
  logic [cPtrW-1:0] pcqWr_q, pcqWr_d, pcqRd_q, pcqRd_d;

  logic [cXLEN-1:0] bufInst_q [pBufDepth];
  logic [cXLEN-1:0] bufPc_q   [pBufDepth];
  logic [cXLEN-1:0] pcq_q     [pBufDepth];

  logic gnt, rspKeep, pop;
  logic redirLsbUnused;

  assign redirLsbUnused = ^iRedirectPc[1:0];

  always_comb begin
    gnt     = memReq_q & iMemGnt;
    rspKeep = iMemRspDv & (discard_q == '0);
    pop     = (bufCnt_q != '0) & ~iStall;

    fetchPc_d = fetchPc_q;
    discard_d = discard_q;
    bufCnt_d  = bufCnt_q;
    bufWr_d   = bufWr_q;
    bufRd_d   = bufRd_q;
    pcqWr_d   = pcqWr_q;
    pcqRd_d   = pcqRd_q;
    outst_d   = outst_q + cCntW'(gnt) - cCntW'(iMemRspDv);

    if (iRedirect) begin
      // Everything in flight at this edge, including a same-cycle grant, is stale.
      fetchPc_d = {iRedirectPc[cXLEN-1:2], 2'b00};
      discard_d = outst_d;
      bufCnt_d  = '0;
      bufWr_d   = '0;
      bufRd_d   = '0;
      pcqWr_d   = '0;
      pcqRd_d   = '0;
    end else begin
      if (gnt) begin
        fetchPc_d = fetchPc_q + 32'd4;
        pcqWr_d   = pcqWr_q + 1'b1;
      end
      if (iMemRspDv) begin
        if (discard_q != '0) begin
          discard_d = discard_q - 1'b1;
        end else begin
          pcqRd_d = pcqRd_q + 1'b1;
          bufWr_d = bufWr_q + 1'b1;
        end
      end
      if (pop) begin
        bufRd_d = bufRd_q + 1'b1;
      end
      bufCnt_d = bufCnt_q + cCntW'(rspKeep) - cCntW'(pop);
    end

    memReq_d = ({1'b0, outst_d} + {1'b0, bufCnt_d}) < cDepth;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      fetchPc_q <= pResetPc;
      memReq_q  <= 1'b0;
      outst_q   <= '0;
      discard_q <= '0;
      bufCnt_q  <= '0;
      bufWr_q   <= '0;
      bufRd_q   <= '0;
      pcqWr_q   <= '0;
      pcqRd_q   <= '0;
    end else begin
      fetchPc_q <= fetchPc_d;
      memReq_q  <= memReq_d;
      outst_q   <= outst_d;
      discard_q <= discard_d;
      bufCnt_q  <= bufCnt_d;
      bufWr_q   <= bufWr_d;
      bufRd_q   <= bufRd_d;
      pcqWr_q   <= pcqWr_d;
      pcqRd_q   <= pcqRd_d;
    end
  end

  // Storage arrays carry no reset; validity is tracked by the counters above.
  always_ff @(posedge iClk) begin
    if (gnt && !iRedirect) begin
      pcq_q[pcqWr_q] <= fetchPc_q;
    end
    if (rspKeep && !iRedirect) begin
      bufInst_q[bufWr_q] <= iMemRspData;
      bufPc_q[bufWr_q]   <= pcq_q[pcqRd_q];
    end
  end

  assign oMemReq  = memReq_q;
  assign oMemAddr = fetchPc_q;
  assign oInstDv  = (bufCnt_q != '0);
  assign oInst    = oInstDv ? bufInst_q[bufRd_q] : cNop;
  assign oCurPc   = oInstDv ? bufPc_q[bufRd_q] : '0;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_inst_fetch: directed scenarios checked every cycle against a transaction-level fetch model.  Rev 1.0
// ----------------------------------------------------------------------------

module tb_inst_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        iClk, iRst;
  logic        oMemReq, iMemGnt, iMemRspDv, iStall, iRedirect, oInstDv;
  logic [31:0] oMemAddr, iMemRspData, iRedirectPc, oInst, oCurPc;

  inst_fetch #(.pResetPc(RESET_PC), .pBufDepth(DEPTH)) dut (
    .iClk(iClk), .iRst(iRst),
    .oMemReq(oMemReq), .oMemAddr(oMemAddr), .iMemGnt(iMemGnt),
    .iMemRspDv(iMemRspDv), .iMemRspData(iMemRspData),
    .iStall(iStall), .iRedirect(iRedirect), .iRedirectPc(iRedirectPc),
    .oInst(oInst), .oCurPc(oCurPc), .oInstDv(oInstDv)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Model: requests in memory tagged with the redirect epoch they belong to.
  typedef struct {
    logic [31:0] addr;
    int          epoch;
    int          due;
  } req_t;

  req_t        mem[$];
  logic [31:0] mBuf[$];
  logic [31:0] log_q[$];
  logic [31:0] mFetchPc;
  int          epoch, cyc, lat, nGrant, firstGnt, firstDv;
  bit          started, stallV, gntV, redirV;
  logic [31:0] redirPc;
  int          nCmp, nErr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit expReq();
    return started && ((mem.size() + mBuf.size()) < DEPTH);
  endfunction

  function automatic logic [31:0] logAt(input int i);
    return (i < log_q.size()) ? log_q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic compare();
    chk("memReq", {31'b0, oMemReq}, {31'b0, expReq()});
    chk("memAddr", oMemAddr, mFetchPc);
    chk("instDv", {31'b0, oInstDv}, {31'b0, mBuf.size() > 0});
    if (mBuf.size() > 0) begin
      chk("curPc", oCurPc, mBuf[0]);
      chk("inst", oInst, mBuf[0]);
    end else begin
      chk("nop", oInst, NOP);
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step();
    req_t        e;
    bit          keep, g;
    logic [31:0] kpc;
    compare();
    if (oInstDv && firstDv < 0) firstDv = cyc;
    iStall      = stallV;
    iRedirect   = redirV;
    iRedirectPc = redirPc;
    iMemGnt     = gntV;
    if (mem.size() > 0 && mem[0].due <= cyc) begin
      iMemRspDv   = 1'b1;
      iMemRspData = mem[0].addr;
    end else begin
      iMemRspDv   = 1'b0;
      iMemRspData = '0;
    end
    if (oInstDv && !stallV && !redirV) log_q.push_back(oCurPc);

    g = expReq() && gntV;
    if (g) begin
      nGrant++;
      if (firstGnt < 0) firstGnt = cyc;
    end
    keep = 1'b0;
    kpc  = '0;
    if (iMemRspDv) begin
      e = mem.pop_front();
      if (!redirV && e.epoch == epoch) begin
        keep = 1'b1;
        kpc  = e.addr;
      end
    end
    if (redirV) begin
      mBuf.delete();
    end else begin
      if (mBuf.size() > 0 && !stallV) void'(mBuf.pop_front());
      if (keep) mBuf.push_back(kpc);
    end
    if (g) mem.push_back('{addr: mFetchPc, epoch: epoch, due: cyc + lat});
    if (redirV) begin
      epoch++;
      mFetchPc = {redirPc[31:2], 2'b00};
    end else if (g) begin
      mFetchPc = mFetchPc + 32'd4;
    end
    started = 1'b1;
    redirV  = 1'b0;
    cyc++;
    @(negedge iClk);
  endtask

  task automatic doReset();
    iRst      = 1'b1;
    iMemRspDv = 1'b0;
    iMemGnt   = 1'b0;
    iRedirect = 1'b0;
    iStall    = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    iRst = 1'b0;
    mem.delete();
    mBuf.delete();
    log_q.delete();
    mFetchPc = RESET_PC;
    started  = 1'b0;
    nGrant   = 0;
    firstGnt = -1;
    firstDv  = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nCmp = 0; nErr = 0; cyc = 0; epoch = 0;
    lat = 1; stallV = 0; gntV = 1; redirV = 0; redirPc = '0;
    iRst = 1'b1; iMemGnt = 0; iMemRspDv = 0; iMemRspData = '0;
    iStall = 0; iRedirect = 0; iRedirectPc = '0;
    doReset();

    // Streaming, 1-cycle memory.
    repeat (12) step();
    chk("t1_latency", firstDv - firstGnt, 32'd2);
    chk("t1_pc0", logAt(0), 32'h0);
    chk("t1_pc1", logAt(1), 32'h4);
    chk("t1_pc2", logAt(2), 32'h8);
    chk("t1_count", log_q.size(), 32'd9);
    chk("t1_pc8", logAt(8), 32'h20);

    // Stall fills the buffer, then drains in order.
    doReset();
    stallV = 1;
    repeat (10) step();
    chk("t2_grants", nGrant, 32'd4);
    chk("t2_req", {31'b0, oMemReq}, 32'd0);
    stallV = 0;
    repeat (8) step();
    chk("t2_pc0", logAt(0), 32'h0);
    chk("t2_pc1", logAt(1), 32'h4);
    chk("t2_pc2", logAt(2), 32'h8);
    chk("t2_pc3", logAt(3), 32'hC);
    chk("t2_pc4", logAt(4), 32'h10);

    // Redirect with two slow requests outstanding.
    doReset();
    lat = 3;
    repeat (3) step();
    log_q.delete();
    redirV = 1; redirPc = 32'h100; gntV = 0;
    step();
    gntV = 1;
    repeat (13) step();
    chk("t3_pc0", logAt(0), 32'h100);
    chk("t3_pc1", logAt(1), 32'h104);

    // Redirect coinciding with a grant and a response, unaligned target.
    doReset();
    lat = 2;
    repeat (6) step();
    log_q.delete();
    redirV = 1; redirPc = 32'h203;
    step();
    chk("t4_addr", oMemAddr, 32'h200);
    repeat (10) step();
    chk("t4_pc0", logAt(0), 32'h200);
    chk("t4_pc1", logAt(1), 32'h204);

    // Address wrap.
    lat = 1;
    log_q.delete();
    redirV = 1; redirPc = 32'hFFFF_FFFC;
    step();
    chk("t5_addr", oMemAddr, 32'hFFFF_FFFC);
    repeat (8) step();
    chk("t5_pc0", logAt(0), 32'hFFFF_FFFC);
    chk("t5_pc1", logAt(1), 32'h0000_0000);

    // Asynchronous reset with a full buffer.
    stallV = 1;
    repeat (8) step();
    chk("t6_full", {31'b0, oInstDv}, 32'd1);
    #2 iRst = 1'b1;
    #1;
    chk("t6_rst_dv", {31'b0, oInstDv}, 32'd0);
    chk("t6_rst_req", {31'b0, oMemReq}, 32'd0);
    chk("t6_rst_inst", oInst, NOP);
    chk("t6_rst_pc", oCurPc, 32'h0);
    doReset();
    stallV = 0;
    repeat (6) step();
    chk("t6_restart", logAt(0), RESET_PC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule

`default_nettype wire
